// File: rtl/core_pkg.sv
// core_pkg: shared fetch-path types and defaults.
// Imported by the fetch unit and its instruction buffer.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small instruction buffer of fetch entries.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [AW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // pointers and occupancy; flush empties the buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  // entry storage, cleared on reset so the head reads zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC, imem req/gnt/rvalid handshake,
// redirect handling with stale-response dropping.
module pc_fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN       = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = core_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            misaligned_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [CW-1:0]   out_q;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   drop_next;
  logic [CW-1:0]   fifo_cnt;
  logic [XLEN-1:0] tgt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            redirect;
  logic            credit;
  logic            req_raw;
  logic            fire;
  logic            drop_rsp;
  logic            push;
  logic            pop;
  fetch_entry_t    head;

  assign misaligned_o = redirect_valid_i && redirect_pc_i[1];
  assign redirect     = redirect_valid_i && !redirect_pc_i[1];
  assign tgt          = {redirect_pc_i[XLEN-1:2], 2'b00};

  assign credit  = !fifo_full &&
                   ((out_q + fifo_cnt) < CW'(FIFO_DEPTH));
  assign req_raw = (state_q == FETCH) && credit;
  assign fire    = req_raw && imem_gnt_i;

  assign imem_req_o  = req_raw && !redirect_valid_i;
  assign imem_addr_o = pc_q;

  assign drop_rsp  = imem_rvalid_i && (drop_q != '0);
  assign push      = imem_rvalid_i && !drop_rsp;
  assign pop       = instr_valid_o && instr_ready_i;
  assign drop_next = out_q + CW'(fire) - CW'(imem_rvalid_i);

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BOOT;
    else         state_q <= state_d;
  end

  // next state: boot once, flush until stale responses drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      FLUSH:   if (drop_rsp && drop_q == CW'(1))
                 state_d = FETCH;
      default: state_d = BOOT;
    endcase
    if (redirect)
      state_d = (drop_next != '0) ? FLUSH : FETCH;
  end

  // fetch pc, response pc, in-flight and drop counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      out_q <= drop_next;
      unique case (1'b1)
        redirect: begin
          pc_q     <= tgt;
          rsp_pc_q <= tgt;
          drop_q   <= drop_next;
        end
        default: begin
          if (fire)     pc_q     <= pc_q + XLEN'(4);
          if (push)     rsp_pc_q <= rsp_pc_q + XLEN'(4);
          if (drop_rsp) drop_q   <= drop_q - CW'(1);
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .entry_i ('{instr: imem_rdata_i, pc: rsp_pc_q}),
    .pop_i   (pop),
    .flush_i (redirect),
    .head_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
